// File: rtl/ps_linebuf_reader.sv
// ps_linebuf_reader
// Consumer end of the pre-process output FIFO. Reads one image row at a time
// into a ring of three line buffers. Once enough rows are buffered it streams
// vertically aligned pixel triplets (top/mid/bottom), one column per beat, to
// the 3x3 Gaussian stage. Row bursts alternate with drains, so the upstream
// FIFO only has to absorb one row.
//
// Optional feature macro: PS_LINEBUF_TOPREP_EN
//   defined   : top-edge replication. Drain starts after two rows; the first
//               output row of a frame uses row 0 as both top and mid.
//   undefined : no replication; FRAME_HEIGHT-2 output rows per frame.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   o_rd                  upstream read enable (combinational)
//   i_data, i_valid       upstream read data and its valid strobe
//   i_empty               upstream (almost-)empty flag
//   i_ready               downstream accepts the current beat
//   o_valid               beat valid
//   o_top, o_mid, o_bot   oldest / middle / newest row pixel of the column
//   o_col                 column of the current beat
//   o_row_last            beat is the last column of its row
//   o_eof                 beat is the last beat of the frame
module ps_linebuf_reader #(
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned LINE_WIDTH   = 640,
  parameter int unsigned FRAME_HEIGHT = 480,
  parameter int unsigned COL_W        = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_rd,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_empty,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_top,
  output logic [DATA_WIDTH-1:0] o_mid,
  output logic [DATA_WIDTH-1:0] o_bot,
  output logic [COL_W-1:0]      o_col,
  output logic                  o_row_last,
  output logic                  o_eof
);

  // Read/write counters must be able to hold LINE_WIDTH itself.
  localparam int unsigned CNT_W = COL_W + 1;
  localparam int unsigned ROW_W = $clog2(FRAME_HEIGHT + 1);

`ifdef PS_LINEBUF_TOPREP_EN
  localparam logic [1:0] DRAIN_ROWS = 2'd2;
`else
  localparam logic [1:0] DRAIN_ROWS = 2'd3;
`endif

  localparam logic [CNT_W-1:0] LINE_CNT = CNT_W'(LINE_WIDTH);
  localparam logic [CNT_W-1:0] LAST_WR  = CNT_W'(LINE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROWS_END = ROW_W'(FRAME_HEIGHT);

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic [1:0]       wr_sel;
  logic [1:0]       rows_filled;
  logic [ROW_W-1:0] in_row;

  logic [DATA_WIDTH-1:0] line_mem [3][LINE_WIDTH];

  logic             wr_en;
  logic             row_done;
  logic [1:0]       rows_filled_inc;
  logic             frame_last;
  logic             beat_load;
  logic             beat_drop;
  logic [COL_W-1:0] load_col;
  logic [1:0]       top_sel;
  logic [1:0]       mid_sel;
  logic [1:0]       bot_sel;

  // Three-entry ring pointer step.
  function automatic logic [1:0] ring_next(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, upstream read enable and datapath strobes.
  always_comb begin
    state_nxt       = state;
    o_rd            = 1'b0;
    wr_en           = 1'b0;
    row_done        = 1'b0;
    beat_load       = 1'b0;
    beat_drop       = 1'b0;
    rows_filled_inc = (rows_filled == 2'd3) ? 2'd3 : rows_filled + 2'd1;
    frame_last      = (in_row == ROWS_END);
    load_col        = o_valid ? o_col + COL_W'(1) : '0;

    // wr_sel always points at the slot after the newest row, which is the
    // oldest row once the ring is full.
    mid_sel = ring_next(wr_sel);
    bot_sel = ring_next(mid_sel);
`ifdef PS_LINEBUF_TOPREP_EN
    // Only two rows buffered: replicate row 0 as the top row.
    top_sel = (rows_filled == 2'd2) ? mid_sel : wr_sel;
`else
    top_sel = wr_sel;
`endif

    case (state)
      ST_FILL: begin
        o_rd     = !i_empty && (rd_cnt < LINE_CNT);
        wr_en    = i_valid && (wr_cnt < LINE_CNT);
        row_done = wr_en && (wr_cnt == LAST_WR);
        if (row_done && (rows_filled_inc >= DRAIN_ROWS)) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // o_valid is low only on the first drain cycle.
        beat_load = !o_valid || (i_ready && !o_row_last);
        beat_drop = o_valid && i_ready && o_row_last;
        if (beat_drop) begin
          state_nxt = ST_FILL;
        end
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  // Row bookkeeping and registered beat outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      wr_sel      <= '0;
      rows_filled <= '0;
      in_row      <= '0;
      o_valid     <= 1'b0;
      o_top       <= '0;
      o_mid       <= '0;
      o_bot       <= '0;
      o_col       <= '0;
      o_row_last  <= 1'b0;
      o_eof       <= 1'b0;
    end else begin
      if (o_rd) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
      if (wr_en) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
      // Row completion overrides the per-pixel increments above.
      if (row_done) begin
        rd_cnt      <= '0;
        wr_cnt      <= '0;
        wr_sel      <= ring_next(wr_sel);
        rows_filled <= rows_filled_inc;
        in_row      <= in_row + ROW_W'(1);
      end

      if (beat_load) begin
        o_valid    <= 1'b1;
        o_top      <= line_mem[top_sel][load_col];
        o_mid      <= line_mem[mid_sel][load_col];
        o_bot      <= line_mem[bot_sel][load_col];
        o_col      <= load_col;
        o_row_last <= (load_col == COL_W'(LINE_WIDTH - 1));
        o_eof      <= frame_last && (load_col == COL_W'(LINE_WIDTH - 1));
      end else if (beat_drop) begin
        o_valid    <= 1'b0;
        o_top      <= '0;
        o_mid      <= '0;
        o_bot      <= '0;
        o_col      <= '0;
        o_row_last <= 1'b0;
        o_eof      <= 1'b0;
        // Last drain of the frame: next fill starts a fresh frame.
        if (frame_last) begin
          rows_filled <= '0;
          in_row      <= '0;
        end
      end
    end
  end

  // Line buffer storage; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      line_mem[wr_sel][wr_cnt[COL_W-1:0]] <= i_data;
    end
  end

endmodule

// File: tb/tb_ps_linebuf_reader.sv
// Testbench for ps_linebuf_reader (LINE_WIDTH=4, FRAME_HEIGHT=5).
// Upstream is a queue-backed FIFO with one cycle read latency; expected beats
// come from a frame-level model built from whole rows of pixels.
module tb_ps_linebuf_reader;

  localparam int unsigned DW = 12;
  localparam int unsigned LW = 4;
  localparam int unsigned FH = 5;
  localparam int unsigned CW = 2;
`ifdef PS_LINEBUF_TOPREP_EN
  localparam int unsigned OUT_ROWS = FH - 1;
`else
  localparam int unsigned OUT_ROWS = FH - 2;
`endif

  typedef struct packed {
    logic [DW-1:0] top;
    logic [DW-1:0] mid;
    logic [DW-1:0] bot;
    logic [CW-1:0] col;
    logic          last;
    logic          eof;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          rd;
  logic [DW-1:0] data;
  logic          valid_in;
  logic          empty;
  logic          ready;
  logic          valid_out;
  logic [DW-1:0] top, mid, bot;
  logic [CW-1:0] col;
  logic          row_last;
  logic          eof;
  beat_t         obs;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] up_q [$];
  beat_t         exp_q [$];
  bit            empty_force = 1'b1;
  int            empty_pct   = 0;
  bit            rd_pend     = 1'b0;
  logic [DW-1:0] rd_data     = '0;

  ps_linebuf_reader #(
    .DATA_WIDTH  (DW),
    .LINE_WIDTH  (LW),
    .FRAME_HEIGHT(FH),
    .COL_W       (CW)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .o_rd      (rd),
    .i_data    (data),
    .i_valid   (valid_in),
    .i_empty   (empty),
    .i_ready   (ready),
    .o_valid   (valid_out),
    .o_top     (top),
    .o_mid     (mid),
    .o_bot     (bot),
    .o_col     (col),
    .o_row_last(row_last),
    .o_eof     (eof)
  );

  always_comb obs = {top, mid, bot, col, row_last, eof};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream FIFO: data read in one cycle is presented the next cycle.
  initial begin
    rst      = 1'b1;
    data     = '0;
    valid_in = 1'b0;
    empty    = 1'b1;
    ready    = 1'b0;
    forever begin
      @(negedge clk);
      valid_in = rd_pend;
      data     = rd_pend ? rd_data : DW'($urandom);
      empty    = empty_force || (up_q.size() == 0) ||
                 ($urandom_range(99) < empty_pct);
      #2;
      rd_pend = rd;
      if (rd && up_q.size() > 0) rd_data = up_q.pop_front();
      else rd_data = DW'($urandom);
    end
  end

  // Frame model: pushes pixels upstream and the expected beats to exp_q.
  task automatic build_frame(input bit rnd);
    logic [DW-1:0] px [FH][LW];
    beat_t e;
    int t, m, b;
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < LW; c++) begin
        px[r][c] = rnd ? DW'($urandom) : DW'(16 * r + c);
        up_q.push_back(px[r][c]);
      end
    for (int k = 0; k < OUT_ROWS; k++) begin
`ifdef PS_LINEBUF_TOPREP_EN
      t = (k == 0) ? 0 : k - 1; m = k; b = k + 1;
`else
      t = k; m = k + 1; b = k + 2;
`endif
      for (int c = 0; c < LW; c++) begin
        e.top  = px[t][c];
        e.mid  = px[m][c];
        e.bot  = px[b][c];
        e.col  = CW'(c);
        e.last = (c == LW - 1);
        e.eof  = (k == OUT_ROWS - 1) && (c == LW - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Streams until every expected beat is accepted, checking each beat,
  // output hold under back-pressure, and read-enable quiet rules.
  task automatic run_stream(input int rdy_pct, input int emp_pct,
                            output beat_t first, output beat_t last);
    int    budget = 3000;
    bit    hold   = 1'b0;
    bit    got    = 1'b0;
    beat_t prev   = '0;
    beat_t e;
    first = '0;
    last  = '0;
    empty_pct   = emp_pct;
    empty_force = 1'b0;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      ready = ($urandom_range(99) < rdy_pct);
      #3;
      budget--;
      if (hold) begin
        total++;
        if (obs !== prev) begin
          bad++;
          $display("FAIL hold: got %h want %h", obs, prev);
        end
      end
      if (valid_out) begin
        total++;
        if (rd !== 1'b0) begin
          bad++;
          $display("FAIL rd_in_drain: got %b want 0", rd);
        end
      end
      if (empty) begin
        total++;
        if (rd !== 1'b0) begin
          bad++;
          $display("FAIL rd_when_empty: got %b want 0", rd);
        end
      end
      hold = valid_out && !ready;
      prev = obs;
      if (valid_out && ready) begin
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL beat: got %h want %h", obs, e);
        end
        if (!got) first = obs;
        got  = 1'b1;
        last = obs;
      end
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d beats left want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    ready = 1'b1;
    #3;
    total++;
    if (valid_out !== 1'b0) begin
      bad++;
      $display("FAIL valid_after_frame: got %b want 0", valid_out);
    end
    total++;
    if (up_q.size() != 0) begin
      bad++;
      $display("FAIL pixels_unread: got %0d want 0", up_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    empty_force = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    total++;
    if (valid_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %b want 0", valid_out);
    end
    total++;
    if (obs !== beat_t'('0)) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #3;
    total++;
    if ({valid_out, rd} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset: got %b want 00", {valid_out, rd});
    end
  endtask

  task automatic test_basic();
    beat_t f, l, wf, wl;
`ifdef PS_LINEBUF_TOPREP_EN
    wf = {12'h000, 12'h000, 12'h010, 2'd0, 1'b0, 1'b0};
`else
    wf = {12'h000, 12'h010, 12'h020, 2'd0, 1'b0, 1'b0};
`endif
    wl = {12'h023, 12'h033, 12'h043, 2'd3, 1'b1, 1'b1};
    build_frame(1'b0);
    run_stream(100, 0, f, l);
    total++;
    if (f !== wf) begin
      bad++;
      $display("FAIL first_beat: got %h want %h", f, wf);
    end
    total++;
    if (l !== wl) begin
      bad++;
      $display("FAIL last_beat: got %h want %h", l, wl);
    end
  endtask

  task automatic test_ready_stall();
    beat_t f, l;
    build_frame(1'b1);
    run_stream(40, 0, f, l);
  endtask

  task automatic test_empty_gap();
    beat_t f, l;
    build_frame(1'b0);
    run_stream(100, 35, f, l);
  endtask

  task automatic test_back_to_back();
    beat_t f, l;
    build_frame(1'b1);
    build_frame(1'b0);
    build_frame(1'b1);
    run_stream(70, 20, f, l);
  endtask

  task automatic test_reset_mid_drain();
    beat_t f, l, wf;
    int nacc   = 0;
    int budget = 500;
    bit hit    = 1'b0;
`ifdef PS_LINEBUF_TOPREP_EN
    wf = {12'h000, 12'h000, 12'h010, 2'd0, 1'b0, 1'b0};
`else
    wf = {12'h000, 12'h010, 12'h020, 2'd0, 1'b0, 1'b0};
`endif
    build_frame(1'b0);
    empty_pct   = 0;
    empty_force = 1'b0;
    while (!hit && budget > 0) begin
      @(negedge clk);
      ready = 1'b1;
      #3;
      budget--;
      if (valid_out) begin
        if (nacc == LW + 1) hit = 1'b1;
        else nacc++;
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL reach_row1_col1: got %0d beats want %0d", nacc, LW + 1);
    end
    rst = 1'b1;
    empty_force = 1'b1;
    #1;
    total++;
    if ({valid_out, obs} !== {1'b0, beat_t'('0)}) begin
      bad++;
      $display("FAIL async_reset: got %b/%h want 0/0", valid_out, obs);
    end
    exp_q.delete();
    up_q.delete();
    rd_pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    build_frame(1'b0);
    run_stream(80, 10, f, l);
    total++;
    if (f !== wf) begin
      bad++;
      $display("FAIL first_beat_after_reset: got %h want %h", f, wf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_stall();
    test_empty_gap();
    test_back_to_back();
    test_reset_mid_drain();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
